// File: rtl/display_pkg.sv
// Shared types and constants for the 3-digit multiplexed 7-segment scanner.
package display_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned AN_W  = 3;

  // Scan order: units, tens, hundreds.
  typedef enum logic [1:0] {
    S_U = 2'd0,
    S_T = 2'd1,
    S_H = 2'd2
  } scan_state_t;

  // Digit positions within the an bus.
  localparam int unsigned DIG_U = 0;
  localparam int unsigned DIG_T = 1;
  localparam int unsigned DIG_H = 2;

  // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // True when the nibble is a legal decimal digit.
  function automatic logic bcd_valid(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high, dash for non-decimal input.
module bcd_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg_c
);

  // Pattern lookup; codes above 9 show a dash.
  always_comb begin
    o_seg_c = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      default: o_seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display999_scan.sv
// Three-digit multiplexed 7-segment scanner for a 0-999 BCD counter, with
// snapshot capture, anti-ghost blanking, leading-zero suppression and an
// invalid-digit flag. All outputs are registered.
module display999_scan
  import display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLANK_CYC = 16,
  parameter bit          ACT_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  input  logic       load,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       err
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Idle levels of the pins for the chosen polarity.
  localparam logic [SEG_W-1:0] SEG_OFF = {SEG_W{ACT_LOW}};
  localparam logic [AN_W-1:0]  AN_OFF  = {AN_W{ACT_LOW}};

  logic [PW-1:0]    r_presc;
  scan_state_t      r_state;
  scan_state_t      w_state_next;
  logic             w_tick;
  logic             w_blank_win;

  logic [BCD_W-1:0] r_u;
  logic [BCD_W-1:0] r_t;
  logic [BCD_W-1:0] r_h;

  logic [BCD_W-1:0] w_digit;
  logic             w_lz_blank;
  logic [AN_W-1:0]  w_an_lit;
  logic [SEG_W-1:0] w_seg_raw;
  logic [SEG_W-1:0] w_seg_next;
  logic [AN_W-1:0]  w_an_next;
  logic             w_err_next;

  logic [SEG_W-1:0] r_seg;
  logic [AN_W-1:0]  r_an;
  logic             r_err;

  assign w_tick      = (r_presc == PW'(SCAN_DIV - 1));
  assign w_blank_win = (r_presc < PW'(BLANK_CYC));

  // Slot prescaler: counts clk cycles within the current digit slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Snapshot of the counter digits, so a changing counter never tears the display.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_u <= '0;
      r_t <= '0;
      r_h <= '0;
    end else if (load) begin
      r_u <= q1;
      r_t <= q2;
      r_h <= q3;
    end
  end

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_U;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next scan state and per-slot digit selection with leading-zero suppression.
  always_comb begin
    w_state_next = r_state;
    w_digit      = r_u;
    w_lz_blank   = 1'b0;
    w_an_lit     = '0;
    case (r_state)
      S_U: begin
        if (w_tick) w_state_next = S_T;
        w_digit         = r_u;
        w_an_lit[DIG_U] = 1'b1;
      end
      S_T: begin
        if (w_tick) w_state_next = S_H;
        w_digit         = r_t;
        w_lz_blank      = (r_h == 4'd0) && (r_t == 4'd0);
        w_an_lit[DIG_T] = 1'b1;
      end
      S_H: begin
        if (w_tick) w_state_next = S_U;
        w_digit         = r_h;
        w_lz_blank      = (r_h == 4'd0);
        w_an_lit[DIG_H] = 1'b1;
      end
      default: begin
        w_state_next = S_U;
      end
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd   (w_digit),
    .o_seg_c (w_seg_raw)
  );

  // Next pin values in active-high form; dark during the anti-ghost window or when suppressed.
  always_comb begin
    w_an_next  = '0;
    w_seg_next = SEG_BLANK;
    if (!w_blank_win && !w_lz_blank) begin
      w_an_next  = w_an_lit;
      w_seg_next = w_seg_raw;
    end
    w_err_next = !bcd_valid(r_u) || !bcd_valid(r_t) || !bcd_valid(r_h);
  end

  // Output registers with polarity applied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
      r_err <= 1'b0;
    end else begin
      r_seg <= w_seg_next ^ SEG_OFF;
      r_an  <= w_an_next ^ AN_OFF;
      r_err <= w_err_next;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;
  assign err = r_err;

endmodule

// File: tb/tb_display999_scan.sv
// Scoreboard bench for display999_scan: one active-high and one active-low
// instance share stimulus; a cycle-count model predicts every output update.
module tb_display999_scan;

  localparam int unsigned SD = 4;
  localparam int unsigned BC = 1;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       load = 1'b0;
  logic [3:0] q1   = '0;
  logic [3:0] q2   = '0;
  logic [3:0] q3   = '0;

  logic [6:0] seg_h, seg_l;
  logic [2:0] an_h, an_l;
  logic       err_h, err_l;

  always #5 clk = ~clk;

  display999_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACT_LOW(1'b0)) u_dut_h (
    .clk(clk), .rst(rst), .q1(q1), .q2(q2), .q3(q3), .load(load),
    .seg(seg_h), .an(an_h), .err(err_h)
  );

  display999_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACT_LOW(1'b1)) u_dut_l (
    .clk(clk), .rst(rst), .q1(q1), .q2(q2), .q3(q3), .load(load),
    .seg(seg_l), .an(an_l), .err(err_l)
  );

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model: cycles elapsed since reset plus the displayed digits.
  int m_n = 0;
  int m_u = 0;
  int m_t = 0;
  int m_h = 0;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  // Active-high output expected from the current model state.
  function automatic exp_t model_out();
    exp_t e;
    int   phase, slot, d;
    bit   dark;
    e     = '0;
    e.err = (m_u > 9) || (m_t > 9) || (m_h > 9);
    phase = m_n % SD;
    slot  = (m_n / SD) % 3;
    d     = (slot == 0) ? m_u : (slot == 1) ? m_t : m_h;
    dark  = (phase < BC) || (slot == 2 && m_h == 0) ||
            (slot == 1 && m_h == 0 && m_t == 0);
    if (!dark) begin
      e.an  = 3'(1 << slot);
      e.seg = seg_of(d);
    end
    return e;
  endfunction

  task automatic step(input bit r, input bit ld, input int d3, input int d2, input int d1);
    exp_t e;
    @(negedge clk);
    rst  = r;
    load = ld;
    q3   = 4'(d3);
    q2   = 4'(d2);
    q1   = 4'(d1);
    if (r) begin
      e   = '0;
      m_n = 0;
      m_u = 0;
      m_t = 0;
      m_h = 0;
    end else begin
      e = model_out();
      m_n++;
      if (ld) begin
        m_u = d1;
        m_t = d2;
        m_h = d3;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, want);
    end
  endtask

  function automatic int rnd_dig();
    return ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
  endfunction

  // Monitor: every output update is compared with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("an_hi",   {4'b0, an_h},  {4'b0, e.an});
        chk("seg_hi",  seg_h,         e.seg);
        chk("err_hi",  {6'b0, err_h}, {6'b0, e.err});
        chk("an_lo",   {4'b0, an_l},  {4'b0, ~e.an});
        chk("seg_lo",  seg_l,         ~e.seg);
        chk("err_lo",  {6'b0, err_l}, {6'b0, e.err});
      end
    end
  end

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    step(1'b1, 1'b0, 0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(3);
    step(1'b0, 1'b1, 1, 2, 3);
    idle(24);
    step(1'b0, 1'b1, 0, 0, 7);
    idle(12);
    step(1'b0, 1'b1, 0, 5, 0);
    idle(12);
    step(1'b0, 1'b1, 0, 0, 12);
    idle(3);
    step(1'b0, 1'b1, 0, 0, 9);
    idle(3);
    // Load on the edge that leaves the units slot.
    repeat (3 * SD) if (!((m_n % SD) == SD - 1 && ((m_n / SD) % 3) == 0)) idle(1);
    step(1'b0, 1'b1, 4, 5, 6);
    idle(12);
    // Reset in the middle of the hundreds slot.
    step(1'b0, 1'b1, 9, 9, 9);
    repeat (3 * SD) if (!((m_n % SD) == 2 && ((m_n / SD) % 3) == 2)) idle(1);
    step(1'b1, 1'b0, 0, 0, 0);
    idle(8);
    repeat (1500) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           rnd_dig(), rnd_dig(), rnd_dig());
    end
    idle(2);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
